// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of an asynchronous slow signal in clk_in cycles.
// Optional GLITCH_FILTER_EN inserts a 3-tap majority filter between the synchroniser and edge detect.
module clock_period_meter #(
   parameter int CNT_W          = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             overflow,
   output logic             timeout
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   s;
   logic                   s_prev_q;
   logic                   rise;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             mv_q, mv_d;
   logic             over_q, over_d;
   logic             to_q, to_d;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
   // Registered majority of the current and two previous synced samples.
   logic [1:0] tap_q;
   logic       filt_q;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         tap_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         tap_q  <= {tap_q[0], sync_out};
         filt_q <= (sync_out & tap_q[0]) | (sync_out & tap_q[1]) | (tap_q[0] & tap_q[1]);
      end
   end

   assign s = filt_q;
`else
   assign s = sync_out;
`endif

   assign rise = s & ~s_prev_q;

   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      hi_d  = (s && hi_q != CNT_MAX) ? hi_q + CNT_ONE : hi_q;
      if (rise) begin
         cnt_d = '0;
         hi_d  = CNT_ONE;
      end
   end

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      high_d   = high_q;
      over_d   = over_q;
      to_d     = to_q;
      mv_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) state_d = ST_ARMED;
         end
         ST_ARMED, ST_LOCKED: begin
            // A rise on the timeout cycle takes priority over declaring loss.
            if (rise) begin
               state_d  = ST_LOCKED;
               period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
               high_d   = hi_q;
               over_d   = (cnt_q == CNT_MAX);
               to_d     = 1'b0;
               mv_d     = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               state_d = ST_IDLE;
               to_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         s_prev_q <= 1'b0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         period_q <= '0;
         high_q   <= '0;
         mv_q     <= 1'b0;
         over_q   <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         s_prev_q <= s;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         period_q <= period_d;
         high_q   <= high_d;
         mv_q     <= mv_d;
         over_q   <= over_d;
         to_q     <= to_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign meas_valid = mv_q;
   assign locked     = (state_q == ST_LOCKED);
   assign overflow   = over_q;
   assign timeout    = to_q;

endmodule
